uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clk cycles per UART bit; minimum 4.
REQ-002 Parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-003 Parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter FIFO_DEPTH, default 16, meaning receive FIFO entries; power of two, at least 2.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-low.
REQ-007 rx  input  1  asynchronous serial line; idles high.
REQ-008 rd_en  input  1  pop request for the FIFO head.
REQ-009 err_clr  input  1  clears all sticky error flags.
REQ-010 rd_data  output  8  FIFO head, show-ahead; unused upper bits are 0 when DATA_BITS<8.
REQ-011 rd_valid  output  1  FIFO non-empty.
REQ-012 count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 frame_err, parity_err, overrun  output  1 each  sticky error flags.

Function
REQ-014 rx passes through a 2-flop synchroniser; both flops load 1 at reset; all decoding uses the synchronised value.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-016 IDLE: a synchronised falling edge -> START, with the bit counter loaded to CLKS_PER_BIT/2-1.
REQ-017 START: at the mid-bit sample, a low line -> DATA; a high line -> IDLE (glitch rejected, nothing reported).
REQ-018 DATA: sample every CLKS_PER_BIT cycles from the start mid-point; shift in LSB first; after DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
REQ-019 PARITY: the sampled bit is checked against odd/even parity of the data; a mismatch marks the frame bad-parity.
REQ-020 STOP, sample high with good parity: push the byte; -> IDLE.
REQ-021 STOP, sample high with bad parity: set parity_err; discard the byte; -> IDLE.
REQ-022 STOP, sample low: set frame_err; discard the byte; -> WAIT_HIGH.
REQ-023 WAIT_HIGH: stay until the synchronised line is high, then -> IDLE (no re-trigger on a held break).
REQ-024 Latency: a pushed byte appears on rd_data/rd_valid the cycle after the stop-bit sample edge.
REQ-025 FIFO push while full without a same-cycle pop: byte dropped, overrun set, contents unchanged.
REQ-026 Simultaneous push and pop, including when full: both take effect; count unchanged.
REQ-027 rd_en while empty: ignored; no pointer change.
REQ-028 Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by the extra pointer bit.
REQ-029 err_clr clears the flags the cycle after it is sampled; a same-cycle new error wins and the flag stays set.

Reset
REQ-030 When rst=0 at a clk edge: FSM to IDLE, counters and pointers to 0, count=0, rd_valid=0, rd_data=0, all error flags 0.
REQ-031 Reset mid-frame abandons the frame; no push occurs, no error is flagged, and after release a new start bit is required.

Structure
REQ-032 The shared package uart_pkg holds the FSM state enum, the PARITY_NONE/ODD/EVEN constants and the default CLKS_PER_BIT.
REQ-033 One sub-module, sync_fifo (parameters WIDTH, DEPTH), holds the storage, pointers and count; the FSM lives in uart_rx.

Verification
REQ-034 Defaults; send 0xA5 as 8N1 at 16 clk/bit -> rd_valid rises 1 cycle after the stop sample; rd_data=0xA5; count=1.
REQ-035 PARITY=2; send 0x03 with parity bit 1 -> parity_err=1, count=0; pulse err_clr -> parity_err=0.
REQ-036 Send 0x55 with stop bit held low for 3 bit times -> frame_err=1, nothing pushed, no spurious frame, then 0x12 is received correctly.
REQ-037 rx low pulse of 4 clk -> no push, FSM returns to IDLE, no flags set.
REQ-038 FIFO_DEPTH=4; send 5 bytes 0x01..0x05 with no reads -> count=4, overrun=1; reads return 0x01..0x04; rd_en when empty leaves count=0.
REQ-039 Assert rst=0 mid-data-bit, then release -> all outputs 0; a following 0x7E is received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Imported by the receiver top, its FIFO and the testbench.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Full and empty are told apart by the extra pointer bit.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = !empty;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchroniser, mid-bit sampling FSM with
// optional parity, sticky error flags and a receive FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  uart_state_t          state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 par_exp;
  logic                 tick;
  logic                 push;
  logic                 fifo_full;
  logic [DATA_BITS-1:0] fifo_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign tick    = (cnt == '0);
  assign par_exp = (PARITY == PARITY_ODD) ? ~^shreg : ^shreg;
  assign push    = (state == ST_STOP) && tick &&
                   rx_sync && !par_bad;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // clear first so a same-cycle new error overrides it
      if (err_clr) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
        overrun    <= 1'b0;
      end
      if (push && fifo_full && !rd_en) overrun <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= ST_START;
            cnt   <= HALF;
          end
        end
        ST_START: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_sync) begin
            state   <= ST_DATA;
            cnt     <= FULL;
            bit_idx <= '0;
            par_bad <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST)
              state <= (PARITY != PARITY_NONE) ? ST_PARITY
                                               : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            par_bad <= (rx_sync != par_exp);
            cnt     <= FULL;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else if (rx_sync) begin
            if (par_bad) parity_err <= 1'b1;
            state <= ST_IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (rd_en),
    .rd_data   (fifo_q),
    .rd_valid  (rd_valid),
    .full      (fifo_full),
    .count     (count)
  );

  always_comb begin
    rd_data = '0;
    rd_data[DATA_BITS-1:0] = fifo_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default, even-parity and
// shallow-FIFO instances driven on separate serial lines.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] rx_v = 3'b111;
  logic [2:0] rd_en = 3'b000;
  logic [2:0] err_clr = 3'b000;

  logic [7:0] d_data, p_data, f_data;
  logic       d_valid, p_valid, f_valid;
  logic [4:0] d_count, p_count;
  logic [2:0] f_count;
  logic       d_fe, d_pe, d_ov;
  logic       p_fe, p_pe, p_ov;
  logic       f_fe, f_pe, f_ov;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  uart_rx u_def (
    .clk(clk), .rst(rst), .rx(rx_v[0]),
    .rd_en(rd_en[0]), .err_clr(err_clr[0]),
    .rd_data(d_data), .rd_valid(d_valid),
    .count(d_count), .frame_err(d_fe),
    .parity_err(d_pe), .overrun(d_ov)
  );

  uart_rx #(.PARITY(PARITY_EVEN)) u_par (
    .clk(clk), .rst(rst), .rx(rx_v[1]),
    .rd_en(rd_en[1]), .err_clr(err_clr[1]),
    .rd_data(p_data), .rd_valid(p_valid),
    .count(p_count), .frame_err(p_fe),
    .parity_err(p_pe), .overrun(p_ov)
  );

  uart_rx #(.FIFO_DEPTH(4)) u_ff (
    .clk(clk), .rst(rst), .rx(rx_v[2]),
    .rd_en(rd_en[2]), .err_clr(err_clr[2]),
    .rd_data(f_data), .rd_valid(f_valid),
    .count(f_count), .frame_err(f_fe),
    .parity_err(f_pe), .overrun(f_ov)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic put_bit(input int s, input logic b);
    rx_v[s] = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int s,
                            input logic [7:0] d,
                            input bit has_par,
                            input logic pb,
                            input int stop_low);
    put_bit(s, 1'b0);
    for (int i = 0; i < 8; i++) put_bit(s, d[i]);
    if (has_par) put_bit(s, pb);
    for (int i = 0; i < stop_low; i++) put_bit(s, 1'b0);
    put_bit(s, 1'b1);
  endtask

  task automatic pulse(input int s, input bit clr);
    if (clr) err_clr[s] = 1'b1;
    else     rd_en[s]   = 1'b1;
    @(negedge clk);
    err_clr[s] = 1'b0;
    rd_en[s]   = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_valid", d_valid, 1'b0);
    chk("rst_data", d_data, 8'h00);
    chk("rst_count", d_count, 5'd0);
    chk("rst_flags", {d_fe, d_pe, d_ov}, 3'b000);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: stop sampled on the 155th edge after start
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 0);
      begin
        repeat (154) @(negedge clk);
        chk("a5_early", d_valid, 1'b0);
        @(negedge clk);
        chk("a5_valid", d_valid, 1'b1);
        chk("a5_data", d_data, 8'hA5);
        chk("a5_count", d_count, 5'd1);
      end
    join
    pulse(0, 1'b0);
    chk("a5_pop", d_count, 5'd0);

    // even parity: 0x03 needs parity 0, send 1
    send_frame(1, 8'h03, 1'b1, 1'b1, 0);
    chk("par_err", p_pe, 1'b1);
    chk("par_count", p_count, 5'd0);
    pulse(1, 1'b1);
    chk("par_clr", p_pe, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b1, 0);
    chk("par_good", p_data, 8'h07);
    chk("par_good_err", p_pe, 1'b0);

    // held-low stop bit
    send_frame(0, 8'h55, 1'b0, 1'b0, 3);
    chk("fe_flag", d_fe, 1'b1);
    chk("fe_count", d_count, 5'd0);
    chk("fe_state", 32'(u_def.state), 32'(ST_IDLE));
    pulse(0, 1'b1);
    send_frame(0, 8'h12, 1'b0, 1'b0, 0);
    chk("fe_next_data", d_data, 8'h12);
    chk("fe_next_count", d_count, 5'd1);
    chk("fe_cleared", d_fe, 1'b0);
    pulse(0, 1'b0);

    // 4-cycle glitch
    rx_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("gl_count", d_count, 5'd0);
    chk("gl_state", 32'(u_def.state), 32'(ST_IDLE));
    chk("gl_flags", {d_fe, d_pe, d_ov}, 3'b000);

    // overrun on a 4-deep FIFO
    for (int i = 1; i <= 5; i++)
      send_frame(2, 8'(i), 1'b0, 1'b0, 0);
    chk("ov_count", f_count, 3'd4);
    chk("ov_flag", f_ov, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ov_rd%0d", i), f_data, 8'(i));
      pulse(2, 1'b0);
    end
    chk("ov_empty", f_valid, 1'b0);
    pulse(2, 1'b0);
    chk("ov_empty_rd", f_count, 3'd0);

    // reset during data bits
    put_bit(0, 1'b0);
    put_bit(0, 1'b0);
    put_bit(0, 1'b0);
    put_bit(0, 1'b1);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx_v[0] = 1'b1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("mr_valid", d_valid, 1'b0);
    chk("mr_data", d_data, 8'h00);
    chk("mr_count", d_count, 5'd0);
    chk("mr_flags", {d_fe, d_pe, d_ov}, 3'b000);
    chk("mr_ovf", f_ov, 1'b0);
    send_frame(0, 8'h7E, 1'b0, 1'b0, 0);
    chk("mr_7e_data", d_data, 8'h7E);
    chk("mr_7e_count", d_count, 5'd1);
    chk("mr_7e_flags", {d_fe, d_pe, d_ov}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
